// File: rtl/exp2_gen_pkg.sv
// Shared crypto_lib_v2 definitions used by the power-of-two generator:
// FSM state encoding and the default operand widths.
// No logic lives here.
package exp2_gen_pkg;

  localparam int unsigned NBITS_DEF = 2048;
  localparam int unsigned KBITS_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/exp2_gen.sv
// Serially builds 2^k (one-hot) or 2^k-1 (low mask) in an NBITS-wide register.
// Latency: done_irq_p in the cycle after edge E0+min(k,NBITS); k=0 finishes right after E0.
// Starts are accepted only in IDLE; enable_p during SHIFT or DONE is dropped.
module exp2_gen
  import exp2_gen_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned KBITS = KBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_p,
  input  logic [KBITS-1:0] k,
  input  logic             mask_mode,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             ovf,
  output logic             done_irq_p
);

  // The counter must be able to hold NBITS itself (the overflow clamp value).
  localparam int unsigned CW = $clog2(NBITS + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] y_q, y_d;
  logic             mode_q, mode_d;
  logic             ovf_r_q, ovf_r_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             k_big;

  // Exponent at or beyond the register width: the count is clamped and ovf reported.
  always_comb k_big = (32'(k) >= NBITS);

  // Next-state, shifter and counter; done/ovf are registered so outputs stay flop-driven.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    mode_d  = mode_q;
    ovf_r_d = ovf_r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_p) begin
          mode_d  = mask_mode;
          ovf_r_d = k_big;
          cnt_d   = k_big ? CW'(NBITS) : CW'(k);
          y_d     = mask_mode ? '0 : {{(NBITS-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
          state_d = (k == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The latched mode is exactly the bit shifted in: 0 moves the one, 1 grows the mask.
        y_d   = {y_q[NBITS-2:0], mode_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // DONE is only ever entered from IDLE or SHIFT, so this marks the single pulse cycle.
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
      ovf_d  = ovf_r_d;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
      ovf_r_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      ovf_r_q <= ovf_r_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign y          = y_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign done_irq_p = done_q;

endmodule
